// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, datapath mux
// selects, ALU controls and the instruction field codes the decoder matches against.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BRANCH,
        UNKNOWN
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_REG = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;
    localparam logic [1:0] OP_UNDEF  = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/mc_cond_check.sv
// NZCV flag registers and condition evaluation; the verdict is captured once per
// instruction (during DECODE) so later states see a stable CondExReg.
module mc_cond_check
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       cond_latch,
    output logic       cond_ex_reg
);

    logic [3:0] nzcv;
    logic       n, z, c, v;
    logic       cond_ex;

    assign {n, z, c, v} = nzcv;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

    // Flag writes are gated by the latched verdict, so a failed condition leaves NZCV alone
    always_ff @(posedge clk) begin
        if (reset) begin
            nzcv        <= 4'b0000;
            cond_ex_reg <= 1'b0;
        end else begin
            if (cond_latch) cond_ex_reg <= cond_ex;
            if (flag_w[1] && cond_ex_reg) nzcv[3:2] <= alu_flags[3:2];
            if (flag_w[0] && cond_ex_reg) nzcv[1:0] <= alu_flags[1:0];
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle ARM control unit: main FSM, ALU/instruction decode and write gating.
// Define MC_MEMWAIT_EN to add a MemReady handshake that stalls FETCH, MEMRD and MEMWR.
module mc_control_unit
    import mc_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
`ifdef MC_MEMWAIT_EN
    input  logic         MemReady,
`endif
    output logic         PCWrite,
    output logic         RegWrite,
    output logic         MemWrite,
    output logic         IRWrite,
    output logic         AdrSrc,
    output logic [1:0]   RegSrc,
    output logic [1:0]   ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ResultSrc,
    output logic [1:0]   ImmSrc,
    output logic [2:0]   ALUControl
);

    logic       mem_ready;
`ifdef MC_MEMWAIT_EN
    assign mem_ready = MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = Instr[31:28];
    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign cmd       = funct[4:1];
    assign rd        = Instr[15:12];
    assign unused_rn = ^Instr[19:16];

    state_t state, next_state, out_state;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:    if (mem_ready) next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_DP:     next_state = funct[5] ? EXECUTEI : EXECUTER;
                    OP_MEM:    next_state = MEMADR;
                    OP_BRANCH: next_state = BRANCH;
                    default:   next_state = UNKNOWN;
                endcase
            end
            MEMADR:   next_state = funct[0] ? MEMRD : MEMWR;
            MEMRD:    if (mem_ready) next_state = MEMWB;
            MEMWR:    if (mem_ready) next_state = FETCH;
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            default:  next_state = FETCH;
        endcase
    end

    // ALU command decode; unknown commands fall back to ADD and write nothing
    logic [2:0] dec_control;
    logic       cmd_valid, cmd_arith, no_write;

    always_comb begin
        dec_control = ALU_ADD;
        cmd_valid   = 1'b1;
        cmd_arith   = 1'b1;
        no_write    = 1'b0;
        case (cmd)
            CMD_ADD: dec_control = ALU_ADD;
            CMD_SUB: dec_control = ALU_SUB;
            CMD_AND: begin dec_control = ALU_AND; cmd_arith = 1'b0; end
            CMD_ORR: begin dec_control = ALU_ORR; cmd_arith = 1'b0; end
            CMD_CMP: begin dec_control = ALU_SUB; no_write = 1'b1; end
            default: begin cmd_valid = 1'b0; cmd_arith = 1'b0; no_write = 1'b1; end
        endcase
    end

    // While reset is held the outputs show the FETCH decode regardless of the stale state
    assign out_state = reset ? FETCH : state;

    logic next_pc, branch, regw, memw, ir_write, alu_op, cond_latch;

    always_comb begin
        next_pc    = 1'b0;
        branch     = 1'b0;
        regw       = 1'b0;
        memw       = 1'b0;
        ir_write   = 1'b0;
        alu_op     = 1'b0;
        cond_latch = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        case (out_state)
            FETCH: begin
                ir_write  = mem_ready;
                next_pc   = mem_ready;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            DECODE: begin
                cond_latch = 1'b1;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
            end
            MEMADR:   ALUSrcB = SRCB_IMM;
            MEMRD:    AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = RES_DATA;
                regw      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                memw   = 1'b1;
            end
            EXECUTER: alu_op = 1'b1;
            EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                alu_op  = 1'b1;
            end
            ALUWB:    regw = ~no_write;
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    logic [1:0] flag_w;
    logic       cond_ex_reg;

    assign ALUControl = alu_op ? dec_control : ALU_ADD;
    assign flag_w     = alu_op ? {funct[0] & cmd_valid, funct[0] & cmd_arith} : 2'b00;

    mc_cond_check u_cond_check (
        .clk         (clk),
        .reset       (reset),
        .cond        (cond),
        .alu_flags   (ALUFlags),
        .flag_w      (flag_w),
        .cond_latch  (cond_latch),
        .cond_ex_reg (cond_ex_reg)
    );

    assign ImmSrc   = op;
    assign RegSrc   = {(op == OP_MEM) & ~funct[0], op == OP_BRANCH};
    assign IRWrite  = ~reset & ir_write;
    assign RegWrite = ~reset & regw & cond_ex_reg;
    assign MemWrite = ~reset & memw & cond_ex_reg;
    assign PCWrite  = ~reset & (next_pc | (cond_ex_reg & (branch | (regw & (rd == 4'hF)))));

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: directed instruction sequences plus random
// instructions, compared per cycle against an instruction-level model of the control unit.
module tb_mc_control_unit;

    logic        clk;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
`ifdef MC_MEMWAIT_EN
    logic        MemReady;
`endif
    logic        PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;

    int checks   = 0;
    int failures = 0;
    logic [3:0] nzcv = 4'b0000;

    localparam int PH_FETCH = 0, PH_DECODE = 1, PH_ADR = 2, PH_RD = 3, PH_WB = 4, PH_WR = 5;
    localparam int PH_EXR = 6, PH_EXI = 7, PH_ALUWB = 8, PH_BR = 9, PH_UNK = 10;

    mc_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
`ifdef MC_MEMWAIT_EN
        .MemReady   (MemReady),
`endif
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc,
                  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

    function automatic logic [17:0] pack(input logic pcw, input logic rw, input logic mw,
                                         input logic irw, input logic adr, input logic [1:0] rs,
                                         input logic [1:0] sa, input logic [1:0] sb,
                                         input logic [1:0] res, input logic [1:0] imm,
                                         input logic [2:0] ctl);
        return {pcw, rw, mw, irw, adr, rs, sa, sb, res, imm, ctl};
    endfunction

    // ARM condition semantics: even codes test a base predicate, odd codes invert it
    function automatic logic condHolds(input logic [3:0] cond, input logic [3:0] f);
        logic r;
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond[3:1])
            3'd0: r = z;
            3'd1: r = c;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = c && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (cond == 4'hF) r = 1'b0;
        else if (cond[0] && cond[3:1] != 3'd7) r = !r;
        return r;
    endfunction

    function automatic bit cmdValid(input logic [3:0] cmd);
        return cmd == 4'd0 || cmd == 4'd2 || cmd == 4'd4 || cmd == 4'd10 || cmd == 4'd12;
    endfunction

    function automatic bit cmdArith(input logic [3:0] cmd);
        return cmd == 4'd2 || cmd == 4'd4 || cmd == 4'd10;
    endfunction

    function automatic logic [2:0] aluFor(input logic [3:0] cmd);
        case (cmd)
            4'd2, 4'd10: return 3'b001;
            4'd0:        return 3'b010;
            4'd12:       return 3'b011;
            default:     return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] regSrcFor(input logic [19:0] instr);
        return {instr[15:14] == 2'b01 && !instr[8], instr[15:14] == 2'b10};
    endfunction

    function automatic logic [17:0] resetVec(input logic [19:0] instr);
        return pack(0, 0, 0, 0, 0, regSrcFor(instr), 2'b01, 2'b10, 2'b10, instr[15:14], 3'b000);
    endfunction

    function automatic logic [17:0] expectVec(input int ph, input logic [19:0] instr,
                                              input logic cpass);
        logic [3:0] cmd;
        logic       pcw, rw, mw, irw, adr, dp_writes, rd_pc;
        logic [1:0] sa, sb, res;
        logic [2:0] ctl;
        cmd = instr[12:9];
        dp_writes = cmdValid(cmd) && cmd != 4'd10;
        rd_pc = (instr[3:0] == 4'hF);
        {pcw, rw, mw, irw, adr} = 5'b0;
        sa = 2'b00; sb = 2'b00; res = 2'b00; ctl = 3'b000;
        case (ph)
            PH_FETCH:  begin sa = 2'b01; sb = 2'b10; res = 2'b10; irw = 1; pcw = 1; end
            PH_DECODE: begin sa = 2'b01; sb = 2'b10; res = 2'b10; end
            PH_ADR:    sb = 2'b01;
            PH_RD:     adr = 1;
            PH_WB:     begin res = 2'b01; rw = cpass; pcw = cpass && rd_pc; end
            PH_WR:     begin adr = 1; mw = cpass; end
            PH_EXR:    ctl = aluFor(cmd);
            PH_EXI:    begin sb = 2'b01; ctl = aluFor(cmd); end
            PH_ALUWB:  begin rw = cpass && dp_writes; pcw = cpass && dp_writes && rd_pc; end
            PH_BR:     begin sb = 2'b01; res = 2'b10; pcw = cpass; end
            default: ;
        endcase
        return pack(pcw, rw, mw, irw, adr, regSrcFor(instr), sa, sb, res, instr[15:14], ctl);
    endfunction

    task automatic checkOutput(input string tag, input logic [17:0] got, input logic [17:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=%b want=%b", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [19:0] instr, input logic [3:0] flags);
        @(negedge clk);
        reset    = 1'b0;
        Instr    = instr;
        ALUFlags = flags;
`ifdef MC_MEMWAIT_EN
        MemReady = 1'b1;
`endif
        #1;
    endtask

    // Runs one instruction through every cycle; abort_at >= 0 asserts reset at that cycle
    task automatic runInstr(input logic [19:0] instr, input logic [3:0] exec_flags,
                            input string name, input int abort_at);
        int         ph[$];
        logic [5:0] funct;
        logic       cpass;
        logic [3:0] flags;
        bit         is_exec;
        funct = instr[13:8];
        cpass = condHolds(instr[19:16], nzcv);
        ph.push_back(PH_FETCH);
        ph.push_back(PH_DECODE);
        case (instr[15:14])
            2'b00: begin ph.push_back(funct[5] ? PH_EXI : PH_EXR); ph.push_back(PH_ALUWB); end
            2'b01: begin
                ph.push_back(PH_ADR);
                if (funct[0]) begin ph.push_back(PH_RD); ph.push_back(PH_WB); end
                else ph.push_back(PH_WR);
            end
            2'b10: ph.push_back(PH_BR);
            default: ph.push_back(PH_UNK);
        endcase
        for (int i = 0; i < ph.size(); i++) begin
            if (i == abort_at) begin
                @(negedge clk);
                reset = 1'b1;
                #1;
                checkOutput($sformatf("%s reset-at-ph%0d", name, ph[i]), obs, resetVec(instr));
                nzcv = 4'b0000;
                return;
            end
            is_exec = (ph[i] == PH_EXR || ph[i] == PH_EXI);
            flags = is_exec ? exec_flags : 4'($urandom);
            applyStimulus(instr, flags);
            checkOutput($sformatf("%s ph%0d", name, ph[i]), obs, expectVec(ph[i], instr, cpass));
            if (is_exec && cpass && funct[0] && cmdValid(funct[4:1])) begin
                nzcv[3:2] = flags[3:2];
                if (cmdArith(funct[4:1])) nzcv[1:0] = flags[1:0];
            end
        end
    endtask

`ifdef MC_MEMWAIT_EN
    task automatic stallFetch(input logic [19:0] instr, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            reset    = 1'b0;
            Instr    = instr;
            ALUFlags = 4'b0000;
            MemReady = 1'b0;
            #1;
            checkOutput($sformatf("stall%0d", k), obs, resetVec(instr));
        end
    endtask
`endif

    initial begin
        logic [19:0] ri;
        reset    = 1'b1;
        Instr    = 20'hE0812;
        ALUFlags = 4'b0000;
`ifdef MC_MEMWAIT_EN
        MemReady = 1'b1;
`endif
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            checkOutput("reset", obs, resetVec(Instr));
        end

        runInstr(20'hE0812, 4'($urandom), "ADD", -1);
        runInstr(20'hE5901, 4'($urandom), "LDR", -1);
        runInstr(20'hE5801, 4'($urandom), "STR", -1);
        runInstr(20'hE0500, 4'b0100, "SUBS_Z", -1);
        runInstr(20'h0A000, 4'($urandom), "BEQ_taken", -1);
        runInstr(20'hE0500, 4'b0000, "SUBS_NZ", -1);
        runInstr(20'h0A000, 4'($urandom), "BEQ_not", -1);
        runInstr(20'hF0812, 4'($urandom), "ADD_NV", -1);
        runInstr(20'hEC000, 4'($urandom), "OP11", -1);
        runInstr(20'hE081F, 4'($urandom), "ADD_PC", -1);

        // Flags set, then reset lands in MEMWR: flags must clear so BEQ is not taken
        runInstr(20'hE0500, 4'b0100, "SUBS_Z2", -1);
        runInstr(20'hE5801, 4'($urandom), "STR_rst", 3);
        runInstr(20'h0A000, 4'($urandom), "BEQ_after_rst", -1);

`ifdef MC_MEMWAIT_EN
        stallFetch(20'hE0812, 3);
        runInstr(20'hE0812, 4'($urandom), "ADD_after_stall", -1);
`endif

        for (int t = 0; t < 200; t++) begin
            ri = 20'($urandom);
            if ($urandom_range(1, 0) == 1) ri[19:16] = 4'hE;
            runInstr(ri, 4'($urandom), $sformatf("rnd%0d", t),
                     ($urandom_range(19, 0) == 0) ? int'($urandom_range(3, 1)) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
